ctrl_decode_pipe: RTL and testbench

//  Registered main-control decoder for the RVX10-P ID stage. Decodes the 7-bit opcode into a

---
 rtl/ctrl_pkg.sv | 67 ++++++
 rtl/ctrl_decode_comb.sv | 42 ++++
 rtl/ctrl_decode_pipe.sv | 127 ++++++++++++
 tb/tb_ctrl_decode_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the RVX10-P ID-stage control decoder: opcodes, control-field enums,
// the packed control word and its all-zero bubble value.
package ctrl_pkg;

  localparam logic [6:0] OP_LW      = 7'b0000011;
  localparam logic [6:0] OP_SW      = 7'b0100011;
  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_BEQ     = 7'b1100011;
  localparam logic [6:0] OP_I       = 7'b0010011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] OP_CUSTOM1 = 7'b0101011;
  localparam logic [6:0] OP_CUSTOM2 = 7'b1011011;
  localparam logic [6:0] OP_CUSTOM3 = 7'b1111011;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_IMM = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_CUSTOM = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00, ST_FULL = 2'b01, ST_TRAP = 2'b10
  } state_e;

  typedef struct packed {
    logic        reg_write;
    imm_src_e    imm_src;
    logic        alu_src;
    logic        mem_write;
    result_src_e result_src;
    logic        branch;
    alu_op_e     alu_op;
    logic        jump;
    logic        jump_reg;
    logic [1:0]  custom_idx;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'(15'd0);

  function automatic ctrl_t make_ctrl(input logic rw, input imm_src_e imm, input logic asrc,
                                      input logic mw, input result_src_e res, input logic br,
                                      input alu_op_e aop, input logic j, input logic jr,
                                      input logic [1:0] idx);
    ctrl_t c;
    c.reg_write  = rw;
    c.imm_src    = imm;
    c.alu_src    = asrc;
    c.mem_write  = mw;
    c.result_src = res;
    c.branch     = br;
    c.alu_op     = aop;
    c.jump       = j;
    c.jump_reg   = jr;
    c.custom_idx = idx;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational opcode -> control word table; undecodable opcodes give an all-zero
// word with illegal=1. NUM_CUSTOM selects how many CUSTOM opcodes are recognised.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int NUM_CUSTOM = 1
) (
  input  logic [6:0] op,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (op)
      OP_LW:   ctrl = make_ctrl(1'b1, IMM_I, 1'b1, 1'b0, RES_MEM, 1'b0, ALU_ADD,   1'b0, 1'b0, 2'd0);
      OP_SW:   ctrl = make_ctrl(1'b0, IMM_S, 1'b1, 1'b1, RES_ALU, 1'b0, ALU_ADD,   1'b0, 1'b0, 2'd0);
      OP_R:    ctrl = make_ctrl(1'b1, IMM_I, 1'b0, 1'b0, RES_ALU, 1'b0, ALU_FUNCT, 1'b0, 1'b0, 2'd0);
      OP_BEQ:  ctrl = make_ctrl(1'b0, IMM_B, 1'b0, 1'b0, RES_ALU, 1'b1, ALU_SUB,   1'b0, 1'b0, 2'd0);
      OP_I:    ctrl = make_ctrl(1'b1, IMM_I, 1'b1, 1'b0, RES_ALU, 1'b0, ALU_FUNCT, 1'b0, 1'b0, 2'd0);
      OP_JAL:  ctrl = make_ctrl(1'b1, IMM_J, 1'b0, 1'b0, RES_PC4, 1'b0, ALU_ADD,   1'b1, 1'b0, 2'd0);
      OP_JALR: ctrl = make_ctrl(1'b1, IMM_I, 1'b1, 1'b0, RES_PC4, 1'b0, ALU_ADD,   1'b1, 1'b1, 2'd0);
      OP_LUI:  ctrl = make_ctrl(1'b1, IMM_U, 1'b0, 1'b0, RES_IMM, 1'b0, ALU_ADD,   1'b0, 1'b0, 2'd0);
      OP_CUSTOM0: ctrl = make_ctrl(1'b1, IMM_I, 1'b0, 1'b0, RES_ALU, 1'b0, ALU_CUSTOM, 1'b0, 1'b0, 2'd0);
      OP_CUSTOM1: begin
        if (NUM_CUSTOM > 1) ctrl = make_ctrl(1'b1, IMM_I, 1'b0, 1'b0, RES_ALU, 1'b0, ALU_CUSTOM, 1'b0, 1'b0, 2'd1);
        else illegal = 1'b1;
      end
      OP_CUSTOM2: begin
        if (NUM_CUSTOM > 2) ctrl = make_ctrl(1'b1, IMM_I, 1'b0, 1'b0, RES_ALU, 1'b0, ALU_CUSTOM, 1'b0, 1'b0, 2'd2);
        else illegal = 1'b1;
      end
      OP_CUSTOM3: begin
        if (NUM_CUSTOM > 3) ctrl = make_ctrl(1'b1, IMM_I, 1'b0, 1'b0, RES_ALU, 1'b0, ALU_CUSTOM, 1'b0, 1'b0, 2'd3);
        else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered ID-stage main-control decoder with valid/ready handshake, flush and a saturating
// illegal-opcode counter. Optional feature macro: ILLEGAL_TRAP_EN (adds TRAP state and trap_ack).
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int NUM_CUSTOM = 1,
  parameter int ILL_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           op,
  input  logic                 flush,
`ifdef ILLEGAL_TRAP_EN
  input  logic                 trap_ack,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 RegWrite,
  output logic [2:0]           ImmSrc,
  output logic                 ALUSrc,
  output logic                 MemWrite,
  output logic [1:0]           ResultSrc,
  output logic                 Branch,
  output logic [1:0]           ALUOp,
  output logic                 Jump,
  output logic                 JumpReg,
  output logic [1:0]           CustomIdx,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  state_e               state_r;
  ctrl_t                ctrl_r;
  logic                 illegal_r;
  logic [ILL_CNT_W-1:0] ill_count_r;
  ctrl_t                dec_ctrl_s;
  logic                 dec_illegal_s;
  logic                 accept_s;

  ctrl_decode_comb #(.NUM_CUSTOM(NUM_CUSTOM)) u_decode (
    .op      (op),
    .ctrl    (dec_ctrl_s),
    .illegal (dec_illegal_s)
  );

  // A held illegal word must drain into TRAP, so nothing new may be taken alongside it.
`ifdef ILLEGAL_TRAP_EN
  assign in_ready = !flush && ((state_r == ST_EMPTY) ||
                               ((state_r == ST_FULL) && out_ready && !illegal_r));
`else
  assign in_ready = !flush && ((state_r != ST_FULL) || out_ready);
`endif
  assign accept_s = in_valid && in_ready;

  // Handshake FSM and ID/EX control register; the word is cleared whenever the stage empties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_EMPTY;
      ctrl_r    <= CTRL_NOP;
      illegal_r <= 1'b0;
    end else if (flush) begin
      state_r   <= ST_EMPTY;
      ctrl_r    <= CTRL_NOP;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_r   <= ST_FULL;
            ctrl_r    <= dec_ctrl_s;
            illegal_r <= dec_illegal_s;
          end
        end
        ST_FULL: begin
          if (accept_s) begin
            ctrl_r    <= dec_ctrl_s;
            illegal_r <= dec_illegal_s;
          end else if (out_ready) begin
`ifdef ILLEGAL_TRAP_EN
            state_r   <= illegal_r ? ST_TRAP : ST_EMPTY;
`else
            state_r   <= ST_EMPTY;
`endif
            ctrl_r    <= CTRL_NOP;
            illegal_r <= 1'b0;
          end
        end
`ifdef ILLEGAL_TRAP_EN
        ST_TRAP: begin
          if (trap_ack) state_r <= ST_EMPTY;
        end
`endif
        default: begin
          state_r   <= ST_EMPTY;
          ctrl_r    <= CTRL_NOP;
          illegal_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of accepted illegal opcodes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ill_count_r <= {ILL_CNT_W{1'b0}};
    end else if (accept_s && dec_illegal_s && !(&ill_count_r)) begin
      ill_count_r <= ill_count_r + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = (state_r == ST_FULL);
  assign RegWrite  = ctrl_r.reg_write;
  assign ImmSrc    = ctrl_r.imm_src;
  assign ALUSrc    = ctrl_r.alu_src;
  assign MemWrite  = ctrl_r.mem_write;
  assign ResultSrc = ctrl_r.result_src;
  assign Branch    = ctrl_r.branch;
  assign ALUOp     = ctrl_r.alu_op;
  assign Jump      = ctrl_r.jump;
  assign JumpReg   = ctrl_r.jump_reg;
  assign CustomIdx = ctrl_r.custom_idx;
  assign illegal   = illegal_r;
  assign ill_count = ill_count_r;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Self-checking bench for ctrl_decode_pipe (NUM_CUSTOM=2, ILL_CNT_W=2), default build.
module tb_ctrl_decode_pipe;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] op = 7'd0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       RegWrite, ALUSrc, MemWrite, Branch, Jump, JumpReg, illegal;
  logic [2:0] ImmSrc;
  logic [1:0] ResultSrc, ALUOp, CustomIdx;
  logic [1:0] ill_count;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic        m_valid;
  logic [15:0] m_word;
  int          m_cnt;
  logic        seen_ready;
  logic        m_ready;

  ctrl_decode_pipe #(.NUM_CUSTOM(2), .ILL_CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
    .Branch(Branch), .ALUOp(ALUOp), .Jump(Jump), .JumpReg(JumpReg), .CustomIdx(CustomIdx),
    .illegal(illegal), .ill_count(ill_count)
  );

  always #5 clk = ~clk;

  wire [15:0] got = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp,
                     Jump, JumpReg, CustomIdx, illegal};

  // Expected {RegWr,ImmSrc,ALUSrc,MemWr,ResSrc,Br,ALUOp,Jump,JumpReg,CustomIdx,illegal}
  function automatic logic [15:0] ref_decode(input logic [6:0] o);
    case (o)
      7'b0000011: return {1'b1, 3'b000, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0};
      7'b0100011: return {1'b0, 3'b001, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0};
      7'b0110011: return {1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 2'd0, 1'b0};
      7'b1100011: return {1'b0, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 2'd0, 1'b0};
      7'b0010011: return {1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 2'd0, 1'b0};
      7'b1101111: return {1'b1, 3'b011, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 2'd0, 1'b0};
      7'b1100111: return {1'b1, 3'b000, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 1'b1, 2'd0, 1'b0};
      7'b0110111: return {1'b1, 3'b100, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0};
      7'b0001011: return {1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 2'd0, 1'b0};
      7'b0101011: return {1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 2'd1, 1'b0};
      default:    return 16'd1;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; op = 7'd0;
    m_valid = 1'b0; m_word = 16'd0; m_cnt = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drives one cycle of stimulus and advances the reference model; outputs valid at return.
  task automatic cycle(input logic v, input logic [6:0] o, input logic rdy, input logic fl);
    logic acc;
    @(negedge clk);
    in_valid = v; op = o; out_ready = rdy; flush = fl;
    #1;
    seen_ready = in_ready;
    m_ready = !fl && (!m_valid || rdy);
    acc = v && m_ready;
    @(posedge clk);
    #1;
    if (fl) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_word  = ref_decode(o);
      if (m_word[0] && m_cnt < 3) m_cnt = m_cnt + 1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || got !== 16'd0 || ill_count !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: out_valid=%b word=%h cnt=%0d in_ready=%b, want 0 0000 0 1",
               out_valid, got, ill_count, in_ready);
    end
  endtask

  task automatic test_lw();
    cycle(1'b1, 7'b0000011, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || got !== ref_decode(7'b0000011)) begin
      n_fail++;
      $display("FAIL lw: out_valid=%b word=%h, want 1 %h", out_valid, got, ref_decode(7'b0000011));
    end
  endtask

  task automatic test_hold();
    cycle(1'b1, 7'b0110011, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 7'b0100011, 1'b0, 1'b0);
      n_checks++;
      if (seen_ready !== 1'b0 || out_valid !== 1'b1 || got !== ref_decode(7'b0110011)) begin
        n_fail++;
        $display("FAIL hold[%0d]: in_ready=%b out_valid=%b word=%h, want 0 1 %h",
                 i, seen_ready, out_valid, got, ref_decode(7'b0110011));
      end
    end
    cycle(1'b1, 7'b0100011, 1'b1, 1'b0);
    n_checks++;
    if (seen_ready !== 1'b1 || out_valid !== 1'b1 || got !== ref_decode(7'b0100011)) begin
      n_fail++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b word=%h, want 1 1 %h",
               seen_ready, out_valid, got, ref_decode(7'b0100011));
    end
  endtask

  task automatic test_custom();
    cycle(1'b1, 7'b0101011, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || CustomIdx !== 2'd1 || ALUOp !== 2'b11 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL custom1: valid=%b idx=%0d aluop=%b ill=%b, want 1 1 11 0",
               out_valid, CustomIdx, ALUOp, illegal);
    end
    cycle(1'b1, 7'b1011011, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || got !== 16'd1) begin
      n_fail++;
      $display("FAIL custom2_illegal: valid=%b word=%h, want 1 0001", out_valid, got);
    end
  endtask

  task automatic test_ill_sat();
    logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 7'b0000000, 1'b1, 1'b0);
      n_checks++;
      if (ill_count !== want[i] || illegal !== 1'b1) begin
        n_fail++;
        $display("FAIL ill_sat[%0d]: count=%0d illegal=%b, want %0d 1", i, ill_count, illegal, want[i]);
      end
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 7'b1101111, 1'b0, 1'b0);
    cycle(1'b1, 7'b0000011, 1'b1, 1'b1);
    n_checks++;
    if (seen_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: in_ready=%b out_valid=%b, want 0 0", seen_ready, out_valid);
    end
    cycle(1'b0, 7'b0000000, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_load: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 7'b0010011, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || got !== 16'd0 || ill_count !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid: out_valid=%b word=%h cnt=%0d, want 0 0000 0", out_valid, got, ill_count);
    end
    m_valid = 1'b0; m_word = 16'd0; m_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [6:0] legal [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0001011, 7'b0101011};
    logic [6:0] o;
    for (int i = 0; i < 400; i++) begin
      o = ($urandom_range(3) == 0) ? 7'($urandom) : legal[$urandom_range(9)];
      cycle(1'($urandom), o, ($urandom_range(3) != 0), ($urandom_range(15) == 0));
      n_checks++;
      if (seen_ready !== m_ready || out_valid !== m_valid || ill_count !== 2'(m_cnt) ||
          (m_valid && got !== m_word)) begin
        n_fail++;
        $display("FAIL random[%0d]: rdy=%b valid=%b word=%h cnt=%0d, want %b %b %h %0d",
                 i, seen_ready, out_valid, got, ill_count, m_ready, m_valid, m_word, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_hold();
    test_custom();
    test_flush();
    test_reset_mid();
    test_ill_sat();
    do_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
